// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the two-client multiplier arbiter.
package mult_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   typedef logic req_id_t;

   function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/binary_multiplier.sv
// Combinational unsigned N x N -> 2N multiplier, full-width product.
module binary_multiplier #(
   parameter int N = 24
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);

   // Both operands are zero-extended so the product keeps every bit.
   assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one registered-in/registered-out multiplier between two clients.
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [N-1:0]       req_a [NUM_REQ],
   input  logic [N-1:0]       req_b [NUM_REQ],
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [2*N-1:0]     rsp_p,
   output logic               busy
);

   state_t         r_state;
   state_t         w_next;
   req_id_t        r_id;
   req_id_t        r_last_gnt;
   req_id_t        w_gnt;
   logic           w_hs;
   logic [N-1:0]   r_a_p0;
   logic [N-1:0]   r_b_p0;
   logic [2*N-1:0] r_p_p1;
   logic [2*N-1:0] w_p;

   binary_multiplier #(.N(N)) u_mult (
      .i_a (r_a_p0),
      .i_b (r_b_p0),
      .o_p (w_p)
   );

   always_comb begin
      w_next    = r_state;
      w_gnt     = 1'b0;
      req_ready = '0;
      rsp_valid = '0;

      // Contention goes to whoever was not served last.
      case (req_valid)
         2'b01:   w_gnt = 1'b0;
         2'b10:   w_gnt = 1'b1;
         2'b11:   w_gnt = ~r_last_gnt;
         default: w_gnt = 1'b0;
      endcase

      w_hs = (r_state == IDLE) && req_valid[w_gnt];

      case (r_state)
         IDLE: begin
            if (w_hs) begin
               req_ready = id_onehot(w_gnt);
               w_next    = MUL;
            end
         end
         MUL:  w_next = RESP;
         RESP: begin
            rsp_valid = id_onehot(r_id);
            if (rsp_ready[r_id]) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_id       <= 1'b0;
         r_last_gnt <= 1'b1;
         r_a_p0     <= '0;
         r_b_p0     <= '0;
         r_p_p1     <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            // stage p0: operands captured on the request handshake
            IDLE: begin
               if (w_hs) begin
                  r_a_p0     <= req_a[w_gnt];
                  r_b_p0     <= req_b[w_gnt];
                  r_id       <= w_gnt;
                  r_last_gnt <= w_gnt;
               end
            end
            // stage p1: product registered, held through the response phase
            MUL:     r_p_p1 <= w_p;
            default: ;
         endcase
      end
   end

   assign rsp_p = r_p_p1;
   assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter.
module tb_mult_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [23:0] req_a [2];
   logic [23:0] req_b [2];
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [47:0] rsp_p;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   mult_share_arbiter #(.N(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a[0] = '0; req_a[1] = '0; req_b[0] = '0; req_b[1] = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
      total++; if (rsp_p !== 48'h0) begin bad++; $display("FAIL reset_rsp_p got=%h exp=0", rsp_p); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
   endtask

   task automatic test_single;
      do_reset();
      req_a[0] = 24'd5; req_b[0] = 24'd2; req_valid = 2'b01;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
      tick();
      req_valid = 2'b00;
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_mul got=%b exp=1", busy); end
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_early_valid got=%b exp=00", rsp_valid); end
      tick();
      total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
      total++; if (rsp_p !== 48'd10) begin bad++; $display("FAIL single_rsp_p got=%0d exp=10", rsp_p); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_idle_valid got=%b exp=00", rsp_valid); end
   endtask

   task automatic test_arbitration;
      do_reset();
      req_a[0] = 24'd11; req_b[0] = 24'd4;
      req_a[1] = 24'd9;  req_b[1] = 24'd3;
      req_valid = 2'b11;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL arb_first_ready got=%b exp=01", req_ready); end
      tick();
      req_valid = 2'b10;
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL arb_mul_ready got=%b exp=00", req_ready); end
      tick();
      total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL arb_rsp0_valid got=%b exp=01", rsp_valid); end
      total++; if (rsp_p !== 48'd44) begin bad++; $display("FAIL arb_rsp0_p got=%0d exp=44", rsp_p); end
      rsp_ready = 2'b01;
      #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL arb_rsphs_ready got=%b exp=00", req_ready); end
      tick();
      rsp_ready = 2'b00;
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL arb_second_ready got=%b exp=10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL arb_rsp1_valid got=%b exp=10", rsp_valid); end
      total++; if (rsp_p !== 48'd27) begin bad++; $display("FAIL arb_rsp1_p got=%0d exp=27", rsp_p); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
   endtask

   task automatic test_stall;
      req_a[0] = 24'd7; req_b[0] = 24'd6; req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      req_valid = 2'b11;
      rsp_ready = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=01", i, rsp_valid); end
         total++; if (rsp_p !== 48'd42) begin bad++; $display("FAIL stall_p[%0d] got=%0d exp=42", i, rsp_p); end
         total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, req_ready); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy[%0d] got=%b exp=1", i, busy); end
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_max;
      req_a[1] = 24'hFFFFFF; req_b[1] = 24'hFFFFFF; req_valid = 2'b10;
      #1;
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL max_ready got=%b exp=10", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL max_valid got=%b exp=10", rsp_valid); end
      total++; if (rsp_p !== 48'hFFFFFE000001) begin bad++; $display("FAIL max_p got=%h exp=fffffe000001", rsp_p); end
      rsp_ready = 2'b01;
      tick();
      total++; if (rsp_valid !== 2'b10) begin bad++; $display("FAIL max_wrong_ready_valid got=%b exp=10", rsp_valid); end
      rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_release_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_in_mul;
      req_a[0] = 24'd13; req_b[0] = 24'd10;
      req_a[1] = 24'd2;  req_b[1] = 24'd2;
      req_valid = 2'b11;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmul_first_ready got=%b exp=01", req_ready); end
      tick();
      rst = 1'b1;
      tick();
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rstmul_valid got=%b exp=00", rsp_valid); end
      total++; if (rsp_p !== 48'h0) begin bad++; $display("FAIL rstmul_p got=%h exp=0", rsp_p); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmul_busy got=%b exp=0", busy); end
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rstmul_regrant got=%b exp=01", req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL rstmul_rsp_valid got=%b exp=01", rsp_valid); end
      total++; if (rsp_p !== 48'd130) begin bad++; $display("FAIL rstmul_rsp_p got=%0d exp=130", rsp_p); end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
   endtask

   task automatic test_back_to_back;
      logic [23:0] a_tab [4];
      logic [23:0] b_tab [4];
      logic [47:0] p_tab [4];
      logic [1:0]  oh;
      int          last_cyc;
      a_tab[0] = 24'd2; b_tab[0] = 24'd3; p_tab[0] = 48'd6;
      a_tab[1] = 24'd4; b_tab[1] = 24'd5; p_tab[1] = 48'd20;
      a_tab[2] = 24'd6; b_tab[2] = 24'd7; p_tab[2] = 48'd42;
      a_tab[3] = 24'd8; b_tab[3] = 24'd9; p_tab[3] = 48'd72;
      last_cyc = 0;
      do_reset();
      req_a[0] = a_tab[0]; req_b[0] = b_tab[0];
      req_a[1] = a_tab[1]; req_b[1] = b_tab[1];
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         oh = (k % 2 == 0) ? 2'b01 : 2'b10;
         total++; if (req_ready !== oh) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", k, req_ready, oh); end
         tick();
         if (k + 2 < 4) begin
            req_a[k % 2] = a_tab[k + 2];
            req_b[k % 2] = b_tab[k + 2];
         end
         tick();
         total++; if (rsp_valid !== oh) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", k, rsp_valid, oh); end
         total++; if (rsp_p !== p_tab[k]) begin bad++; $display("FAIL b2b_p[%0d] got=%0d exp=%0d", k, rsp_p, p_tab[k]); end
         if (k > 0) begin
            total++; if (cyc - last_cyc != 3) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", k, cyc - last_cyc); end
         end
         last_cyc = cyc;
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a[0] = '0; req_a[1] = '0; req_b[0] = '0; req_b[1] = '0;
      test_reset();
      test_single();
      test_arbitration();
      test_stall();
      test_max();
      test_reset_in_mul();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
